risc_datapath: RTL and testbench

//  Execution side of the VeriRISC control interface. It holds the phase counter, PC, IR,

---
 rtl/risc_datapath.sv | 106 ++++++++++
 tb/tb_risc_datapath.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc_datapath.sv
// VeriRISC execution datapath: phase counter, PC, IR, accumulator and ALU.
// Acts on the controller strobes and drives the instruction/data memory bus.
module risc_datapath #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              sel,
    input  logic              rd,
    input  logic              ld_ir,
    input  logic              halt,
    input  logic              inc_pc,
    input  logic              ld_ac,
    input  logic              wr,
    input  logic              ld_pc,
    input  logic              data_e,
    output logic [2:0]        phase,
    output logic [2:0]        opcode,
    output logic              zero,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              halted
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    logic [2:0]        phase_q,  phase_d;
    logic [AWIDTH-1:0] pc_q,     pc_d;
    logic [DWIDTH-1:0] ir_q,     ir_d;
    logic [DWIDTH-1:0] ac_q,     ac_d;
    logic              halted_q, halted_d;
    logic [DWIDTH-1:0] alu_result;

    always_comb begin
        alu_result = ac_q;
        case (opcode)
            OP_HLT, OP_SKZ, OP_STO, OP_JMP: alu_result = ac_q;
            OP_ADD:                         alu_result = ac_q + mem_rdata;
            OP_AND:                         alu_result = ac_q & mem_rdata;
            OP_XOR:                         alu_result = ac_q ^ mem_rdata;
            OP_LDA:                         alu_result = mem_rdata;
            default:                        alu_result = ac_q;
        endcase
    end

    // Once halted, every architectural register freezes; only reset releases it.
    // On the edge that halts, the other strobes still land but phase holds.
    always_comb begin
        phase_d  = phase_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ac_d     = ac_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (halt)
                halted_d = 1'b1;
            else
                phase_d = phase_q + 3'd1;
            if (ld_ir)
                ir_d = mem_rdata;
            if (ld_pc)
                pc_d = ir_q[AWIDTH-1:0];
            else if (inc_pc)
                pc_d = pc_q + {{(AWIDTH-1){1'b0}}, 1'b1};
            if (ld_ac)
                ac_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            phase_q  <= 3'd0;
            pc_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            halted_q <= halted_d;
        end
    end

    assign phase     = phase_q;
    assign opcode    = ir_q[DWIDTH-1:DWIDTH-3];
    assign zero      = (ac_q == '0);
    assign halted    = halted_q;
    assign mem_addr  = sel ? pc_q : ir_q[AWIDTH-1:0];
    assign mem_rd    = rd & ~halted_q;
    assign mem_wr    = wr & ~halted_q;
    assign mem_wdata = data_e ? ac_q : '0;

endmodule

// File: tb/tb_risc_datapath.sv
// Directed and randomized bench for risc_datapath against an architectural model
// of PC/IR/AC/phase/halted kept as plain integers.
module tb_risc_datapath;

    logic       clk = 1'b0;
    logic       rst_, sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e;
    logic [7:0] mem_rdata;
    logic [2:0] phase, opcode;
    logic       zero, mem_rd, mem_wr, halted;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    // Architectural model
    int m_phase, m_pc, m_ir, m_ac;
    bit m_halted;
    int obs_pc, obs_ac;

    always #5 clk = ~clk;

    risc_datapath #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk(clk), .rst_(rst_), .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt),
        .inc_pc(inc_pc), .ld_ac(ld_ac), .wr(wr), .ld_pc(ld_pc), .data_e(data_e),
        .phase(phase), .opcode(opcode), .zero(zero), .mem_addr(mem_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int alu(input int op, input int a, input int b);
        case (op)
            2: return (a + b) % 256;
            3: return a & b;
            4: return a ^ b;
            5: return b;
            default: return a;
        endcase
    endfunction

    task automatic clear_strobes();
        sel = 0; rd = 0; ld_ir = 0; halt = 0; inc_pc = 0;
        ld_ac = 0; wr = 0; ld_pc = 0; data_e = 0;
    endtask

    // Read PC and AC back through the bus by briefly steering sel/data_e.
    task automatic check_state(input string tag);
        logic s_sel, s_de;
        s_sel = sel; s_de = data_e;
        sel = 1; data_e = 1;
        #1;
        obs_pc = int'(mem_addr);
        obs_ac = int'(mem_wdata);
        chk({tag, ".pc"}, mem_addr, m_pc);
        chk({tag, ".ac"}, mem_wdata, m_ac);
        chk({tag, ".phase"}, phase, m_phase);
        chk({tag, ".opcode"}, opcode, m_ir / 32);
        chk({tag, ".zero"}, zero, m_ac == 0);
        chk({tag, ".halted"}, halted, m_halted);
        sel = s_sel; data_e = s_de;
        $display("[%0t] %s pc=%0d ac=%02h phase=%0d op=%0d halted=%0b",
                 $time, tag, obs_pc, obs_ac, phase, opcode, halted);
    endtask

    // One clock: check bus outputs for the driven strobes, clock, update model, check state.
    task automatic cycle(input string tag);
        int nphase, npc, nir, nac;
        #1;
        chk({tag, ".addr"}, mem_addr, sel ? m_pc : (m_ir % 32));
        chk({tag, ".rd"}, mem_rd, rd && !m_halted);
        chk({tag, ".wr"}, mem_wr, wr && !m_halted);
        chk({tag, ".wdata"}, mem_wdata, data_e ? m_ac : 0);
        @(posedge clk);
        if (!rst_) begin
            m_phase = 0; m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0;
        end else if (!m_halted) begin
            nphase = halt ? m_phase : (m_phase + 1) % 8;
            nir    = ld_ir ? int'(mem_rdata) : m_ir;
            npc    = ld_pc ? m_ir % 32 : (inc_pc ? (m_pc + 1) % 32 : m_pc);
            nac    = ld_ac ? alu(m_ir / 32, m_ac, int'(mem_rdata)) : m_ac;
            m_phase = nphase; m_pc = npc; m_ir = nir; m_ac = nac;
            if (halt) m_halted = 1;
        end
        #1;
        check_state(tag);
    endtask

    task automatic rand_inputs(input bit allow_halt, input bit allow_rst);
        rst_      = allow_rst ? ($urandom_range(0, 19) != 0) : 1'b1;
        sel       = 1'($urandom);
        rd        = 1'($urandom);
        ld_ir     = 1'($urandom);
        halt      = allow_halt ? ($urandom_range(0, 24) == 0) : 1'b0;
        inc_pc    = 1'($urandom);
        ld_ac     = 1'($urandom);
        wr        = 1'($urandom);
        ld_pc     = ($urandom_range(0, 3) == 0);
        data_e    = 1'($urandom);
        mem_rdata = 8'($urandom);
    endtask

    task automatic load_ir(input logic [7:0] v);
        clear_strobes(); mem_rdata = v; ld_ir = 1; sel = 1;
        cycle("load_ir");
        clear_strobes();
    endtask

    task automatic load_ac(input logic [7:0] v, input string tag);
        clear_strobes(); mem_rdata = v; ld_ac = 1;
        cycle(tag);
        clear_strobes();
    endtask

    task automatic run_to_phase(input int p);
        clear_strobes();
        for (int i = 0; i < 8 && m_phase != p; i++) cycle("idle");
        chk("run_to_phase", phase, p);
    endtask

    initial begin
        m_phase = 0; m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0;
        mem_rdata = 8'h00;
        clear_strobes();
        rst_ = 0;
        cycle("reset0");
        cycle("reset1");
        chk("reset.phase", phase, 0);
        chk("reset.zero", zero, 1);
        chk("reset.halted", halted, 0);

        // Random activity, then reset for two clocks
        for (int i = 0; i < 30; i++) begin
            rand_inputs(1'b0, 1'b0);
            cycle("rand_pre");
        end
        clear_strobes(); rst_ = 0;
        cycle("rst_a"); cycle("rst_b");
        chk("tc1.pc", obs_pc, 0);
        chk("tc1.ac", obs_ac, 0);
        chk("tc1.zero", zero, 1);
        rst_ = 1;

        // Reset mid-instruction at phase 5
        run_to_phase(5);
        rst_ = 0; cycle("rst_mid"); rst_ = 1;
        chk("tc1.mid_phase", phase, 0);

        // Fetch: A3 -> LDA, address field 03
        load_ir(8'hA3);
        chk("tc2.opcode", opcode, 5);
        sel = 0; #1;
        chk("tc2.addr_ir", mem_addr, 5'h03);
        sel = 1; #1;
        chk("tc2.addr_pc", mem_addr, m_pc);
        clear_strobes();

        // ALU: LDA F0, ADD 20 (wraps to 10), XOR 10 -> 0
        load_ac(8'hF0, "lda_f0");
        chk("tc3.lda", obs_ac, 8'hF0);
        load_ir(8'h40);
        load_ac(8'h20, "add_20");
        chk("tc3.add_wrap", obs_ac, 8'h10);
        chk("tc3.zero0", zero, 0);
        load_ir(8'h80);
        load_ac(8'h10, "xor_10");
        chk("tc3.xor", obs_ac, 8'h00);
        chk("tc3.zero1", zero, 1);
        load_ir(8'h60);
        load_ac(8'h3C, "and_3c");
        chk("tc3.and", obs_ac, 8'h00);

        // PC wrap and ld_pc priority
        load_ir(8'hFF);
        ld_pc = 1; cycle("jmp31"); clear_strobes();
        chk("tc4.pc31", obs_pc, 31);
        inc_pc = 1; cycle("inc_wrap"); clear_strobes();
        chk("tc4.wrap", obs_pc, 0);
        load_ir(8'hE7);
        ld_pc = 1; inc_pc = 1; cycle("ldpc_prio"); clear_strobes();
        chk("tc4.prio", obs_pc, 7);

        // Store path
        load_ir(8'hA9);
        load_ac(8'h5A, "lda_5a");
        load_ir(8'hC9);
        data_e = 1; wr = 1; sel = 0; #1;
        chk("tc5.wdata", mem_wdata, 8'h5A);
        chk("tc5.wr", mem_wr, 1);
        chk("tc5.addr", mem_addr, 5'h09);
        cycle("sto");
        data_e = 0; #1;
        chk("tc5.wdata_off", mem_wdata, 8'h00);
        clear_strobes();

        // Halt at phase 4 with a concurrent inc_pc, then 20 frozen clocks
        run_to_phase(4);
        halt = 1; inc_pc = 1; cycle("halt_edge"); clear_strobes();
        chk("tc6.halted", halted, 1);
        chk("tc6.phase_hold", phase, 4);
        for (int i = 0; i < 20; i++) begin
            rand_inputs(1'b0, 1'b0);
            rd = 1;
            cycle("halted");
        end
        chk("tc6.rd_forced", mem_rd, 0);
        clear_strobes(); rst_ = 0; cycle("unhalt"); rst_ = 1;
        chk("tc6.cleared", halted, 0);

        // Fully random tail including occasional halt and reset
        for (int i = 0; i < 300; i++) begin
            rand_inputs(1'b1, 1'b1);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
